// File: rtl/mcbsp_master_link.sv
// McBSP bus master: divides a_clk into mcbsp_clk, frames with fsx, shifts a frame out MSB-first
// and captures the returning frame. Define MCBSP_MASTER_LOOPBACK_EN to sample mcbsp_tx internally.
module mcbsp_master_link #(
  parameter int unsigned WORDS_PER_FRAME = 8,
  parameter int unsigned BITS_PER_WORD   = 32,
  parameter int unsigned CLK_DIV         = 4
) (
  input  logic                                     a_clk,
  input  logic                                     a_reset,
  input  logic                                     start,
  input  logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] tx_frame,
  output logic                                     mcbsp_clk,
  output logic                                     mcbsp_fsx,
  output logic                                     mcbsp_tx,
  input  logic                                     mcbsp_rx,
  output logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] rx_frame,
  output logic                                     rx_valid,
  output logic                                     busy,
  output logic [15:0]                              frame_count
);

  localparam int unsigned N    = WORDS_PER_FRAME * BITS_PER_WORD;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [2:0] {StIdle, StArm, StSync, StShift, StDone} state_e;

  state_e          state_q;
  logic [7:0]      div_cnt_q;
  logic            mcbsp_clk_q;
  logic            mcbsp_fsx_q;
  logic            mcbsp_tx_q;
  logic            rx_valid_q;
  logic            busy_q;
  logic [15:0]     frame_count_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [N-1:0]    tx_shift_q;
  logic [N-1:0]    rx_shift_q;
  logic [N-1:0]    rx_frame_q;

  logic div_wrap;
  logic rise_evt;
  logic fall_evt;
  logic rx_bit;

  assign div_wrap = (div_cnt_q == 8'(CLK_DIV - 1));
  assign rise_evt = div_wrap & ~mcbsp_clk_q;
  assign fall_evt = div_wrap & mcbsp_clk_q;

`ifdef MCBSP_MASTER_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = mcbsp_rx;
  assign rx_bit    = mcbsp_tx_q;
`else
  assign rx_bit    = mcbsp_rx;
`endif

  // Free-running divider; mcbsp_clk toggles each time div_cnt wraps.
  always_ff @(posedge a_clk or posedge a_reset) begin
    if (a_reset) begin
      div_cnt_q   <= 8'd0;
      mcbsp_clk_q <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_q   <= 8'd0;
      mcbsp_clk_q <= ~mcbsp_clk_q;
    end else begin
      div_cnt_q   <= div_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge a_clk or posedge a_reset) begin
    if (a_reset) begin
      state_q       <= StIdle;
      mcbsp_fsx_q   <= 1'b0;
      mcbsp_tx_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= 16'd0;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_frame_q    <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            tx_shift_q <= tx_frame;
            busy_q     <= 1'b1;
            state_q    <= StArm;
          end
        end
        StArm: begin
          if (rise_evt) begin
            mcbsp_fsx_q <= 1'b1;
            state_q     <= StSync;
          end
        end
        StSync: begin
          if (rise_evt) begin
            mcbsp_fsx_q <= 1'b0;
            bit_cnt_q   <= CntW'(N - 1);
            mcbsp_tx_q  <= tx_shift_q[N-1];
            state_q     <= StShift;
          end
        end
        StShift: begin
          // Bit k is driven on a rising edge and sampled on the following falling edge.
          if (fall_evt) begin
            rx_shift_q[bit_cnt_q] <= rx_bit;
            if (bit_cnt_q == '0) begin
              state_q <= StDone;
            end else begin
              bit_cnt_q <= bit_cnt_q - CntW'(1);
            end
          end else if (rise_evt) begin
            mcbsp_tx_q <= tx_shift_q[bit_cnt_q];
          end
        end
        StDone: begin
          rx_frame_q    <= rx_shift_q;
          rx_valid_q    <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
          busy_q        <= 1'b0;
          mcbsp_tx_q    <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mcbsp_clk   = mcbsp_clk_q;
  assign mcbsp_fsx   = mcbsp_fsx_q;
  assign mcbsp_tx    = mcbsp_tx_q;
  assign rx_frame    = rx_frame_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mcbsp_master_link.sv
// Bench for mcbsp_master_link: a CLK_DIV=4 instance with an echo/pattern slave model and a
// CLK_DIV=1 instance for back-to-back frames; expected frames go through scoreboard queues.
module tb_mcbsp_master_link;

  localparam int unsigned Words  = 8;
  localparam int unsigned Bits   = 32;
  localparam int unsigned N      = Words * Bits;
  localparam int unsigned DivS   = 4;
  localparam int unsigned DivF   = 1;
  localparam int          LatMax = (N + 2) * 2 * DivS + 2 * DivS;
  localparam int          GapF   = (N + 2) * 2 * DivF;

  logic a_clk = 1'b0;
  logic a_reset = 1'b1;

  logic         start_s = 1'b0;
  logic [N-1:0] tx_s = '0;
  logic         clk_s, fsx_s, txo_s, val_s, busy_s;
  logic         rx_s = 1'b0;
  logic [N-1:0] rxf_s;
  logic [15:0]  cnt_s;

  logic         start_f = 1'b0;
  logic [N-1:0] tx_f = '0;
  logic         clk_f, fsx_f, txo_f, val_f, busy_f;
  logic         rx_f = 1'b0;
  logic [N-1:0] rxf_f;
  logic [15:0]  cnt_f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] sb_s[$];
  logic [N-1:0] sb_f[$];

  always #5 a_clk = ~a_clk;

  mcbsp_master_link #(
    .WORDS_PER_FRAME(Words), .BITS_PER_WORD(Bits), .CLK_DIV(DivS)
  ) u_dut (
    .a_clk(a_clk), .a_reset(a_reset), .start(start_s), .tx_frame(tx_s),
    .mcbsp_clk(clk_s), .mcbsp_fsx(fsx_s), .mcbsp_tx(txo_s), .mcbsp_rx(rx_s),
    .rx_frame(rxf_s), .rx_valid(val_s), .busy(busy_s), .frame_count(cnt_s)
  );

  mcbsp_master_link #(
    .WORDS_PER_FRAME(Words), .BITS_PER_WORD(Bits), .CLK_DIV(DivF)
  ) u_fast (
    .a_clk(a_clk), .a_reset(a_reset), .start(start_f), .tx_frame(tx_f),
    .mcbsp_clk(clk_f), .mcbsp_fsx(fsx_f), .mcbsp_tx(txo_f), .mcbsp_rx(rx_f),
    .rx_frame(rxf_f), .rx_valid(val_f), .busy(busy_f), .frame_count(cnt_f)
  );

  // Slave model for the slow link: echo mode returns the bit sampled on the previous falling
  // edge; pattern mode drives slave_pat MSB-first starting on the rise that ends fsx.
  bit           slave_pat_mode = 1'b0;
  logic [N-1:0] slave_pat = '0;
  bit           held_s = 1'b0, clks_prev = 1'b0, fsxs_prev = 1'b0;
  int           pidx = 0;
  always @(negedge a_clk) begin
    if (clk_s && !clks_prev) begin
      if (slave_pat_mode) begin
        if (fsxs_prev && !fsx_s) pidx = N - 1;
        else if (pidx > 0) pidx = pidx - 1;
        rx_s = slave_pat[pidx];
      end else begin
        rx_s = held_s;
      end
    end else if (!clk_s && clks_prev) begin
      held_s = txo_s;
    end
    clks_prev = clk_s;
    fsxs_prev = fsx_s;
  end

  bit held_f = 1'b0, clkf_prev = 1'b0;
  always @(negedge a_clk) begin
    if (clk_f && !clkf_prev) rx_f = held_f;
    else if (!clk_f && clkf_prev) held_f = txo_f;
    clkf_prev = clk_f;
  end

  int cyc_cnt = 0, nval_s = 0, nval_f = 0, rise_f_last = 0, rise_f_prev = 0;
  bit fsxf_prev = 1'b0;
  always @(negedge a_clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (val_s) nval_s = nval_s + 1;
    if (val_f) nval_f = nval_f + 1;
    if (fsx_f && !fsxf_prev) begin
      rise_f_prev = rise_f_last;
      rise_f_last = cyc_cnt;
    end
    fsxf_prev = fsx_f;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [N-1:0] exp_echo(input logic [N-1:0] t);
`ifdef MCBSP_MASTER_LOOPBACK_EN
    return t;
`else
    return t >> 1;
`endif
  endfunction

  function automatic logic [N-1:0] exp_pat(input logic [N-1:0] t, input logic [N-1:0] p);
`ifdef MCBSP_MASTER_LOOPBACK_EN
    return t;
`else
    return p;
`endif
  endfunction

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] t;
    for (int i = 0; i < Words; i++) t[i*Bits +: Bits] = $urandom();
    return t;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input bit fast, input logic [N-1:0] obs);
    logic [N-1:0] e;
    e = '0;
    check({tag, "_sb_nonempty"}, N'(fast ? sb_f.size() != 0 : sb_s.size() != 0), N'(1));
    if (fast && sb_f.size() != 0) e = sb_f.pop_front();
    if (!fast && sb_s.size() != 0) e = sb_s.pop_front();
    check(tag, obs, e);
  endtask

  task automatic wait_valid(input bit fast, input int bound, output int cyc, output int fsx_hi,
                            output bit first_tx, output int tx_hi, output bit tout);
    bit pf, fx, tx, vl, done;
    cyc = 0; fsx_hi = 0; tx_hi = 0; first_tx = 1'b0; tout = 1'b0; pf = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge a_clk);
      cyc++;
      fx = fast ? fsx_f : fsx_s;
      tx = fast ? txo_f : txo_s;
      vl = fast ? val_f : val_s;
      if (fx) fsx_hi++;
      if (tx) tx_hi++;
      if (!fx && pf) first_tx = tx;
      pf = fx;
      if (vl) done = 1'b1;
      else if (cyc >= bound) begin
        tout = 1'b1;
        done = 1'b1;
      end
    end
  endtask

  task automatic pulse_start_s();
    start_s = 1'b1;
    @(negedge a_clk);
    start_s = 1'b0;
  endtask

  initial begin
    logic [N-1:0] t;
    int cyc, fhi, thi, v0;
    bit ftx, tout;

    // Reset state
    @(negedge a_clk);
    check("rst_clk", N'(clk_s), N'(0));
    check("rst_fsx", N'(fsx_s), N'(0));
    check("rst_tx", N'(txo_s), N'(0));
    check("rst_busy", N'(busy_s), N'(0));
    check("rst_valid", N'(val_s), N'(0));
    check("rst_rxframe", rxf_s, '0);
    check("rst_count", N'(cnt_s), N'(0));
    repeat (2) @(negedge a_clk);
    a_reset = 1'b0;
    repeat (3) @(negedge a_clk);

    // Echo frame with fixed word pattern
    for (int i = 0; i < Words; i++) t[i*Bits +: Bits] = (i % 2 == 0) ? 32'h89AB_CDEF : 32'h0123_4567;
    tx_s = t;
    sb_s.push_back(exp_echo(t));
    v0 = nval_s;
    pulse_start_s();
    check("f1_busy", N'(busy_s), N'(1));
    wait_valid(1'b0, LatMax + 20, cyc, fhi, ftx, thi, tout);
    check("f1_timeout", N'(tout), N'(0));
    check("f1_latency", N'(cyc <= LatMax), N'(1));
    pop_check("f1_rxframe", 1'b0, rxf_s);
    check("f1_fsx_width", N'(fhi), N'(2 * DivS));
    @(negedge a_clk);
    check("f1_valid_pulse", N'(val_s), N'(0));
    check("f1_nvalid", N'(nval_s - v0), N'(1));
    check("f1_count", N'(cnt_s), N'(1));
    check("f1_busy_end", N'(busy_s), N'(0));

    // Bit order: only MSB set on tx, slave returns only the last bit
    t = '0;
    t[N-1] = 1'b1;
    tx_s = t;
    slave_pat = '0;
    slave_pat[0] = 1'b1;
    slave_pat_mode = 1'b1;
    sb_s.push_back(exp_pat(t, slave_pat));
    pulse_start_s();
    wait_valid(1'b0, LatMax + 20, cyc, fhi, ftx, thi, tout);
    check("f2_timeout", N'(tout), N'(0));
    pop_check("f2_rxframe", 1'b0, rxf_s);
    check("f2_first_bit", N'(ftx), N'(1));
    check("f2_tx_high_cycles", N'(thi), N'(2 * DivS));
    @(negedge a_clk);
    check("f2_count", N'(cnt_s), N'(2));

    // Second start near bit 50 and tx_frame change while busy
    slave_pat_mode = 1'b0;
    t = rand_frame();
    tx_s = t;
    sb_s.push_back(exp_echo(t));
    v0 = nval_s;
    pulse_start_s();
    repeat (52 * 2 * DivS) @(negedge a_clk);
    tx_s = ~t;
    pulse_start_s();
    wait_valid(1'b0, LatMax + 20, cyc, fhi, ftx, thi, tout);
    check("f3_timeout", N'(tout), N'(0));
    pop_check("f3_rxframe", 1'b0, rxf_s);
    repeat (LatMax) @(negedge a_clk);
    check("f3_nvalid", N'(nval_s - v0), N'(1));
    check("f3_count", N'(cnt_s), N'(3));
    check("f3_busy_end", N'(busy_s), N'(0));
    check("f3_sb_drained", N'(sb_s.size()), N'(0));

    // Reset around bit 100 aborts the frame
    t = rand_frame();
    tx_s = t;
    sb_s.push_back(exp_echo(t));
    pulse_start_s();
    repeat (102 * 2 * DivS) @(negedge a_clk);
    check("f4_busy_mid", N'(busy_s), N'(1));
    v0 = nval_s;
    a_reset = 1'b1;
    #1;
    check("rst2_clk", N'(clk_s), N'(0));
    check("rst2_fsx", N'(fsx_s), N'(0));
    check("rst2_tx", N'(txo_s), N'(0));
    check("rst2_busy", N'(busy_s), N'(0));
    check("rst2_valid", N'(val_s), N'(0));
    check("rst2_rxframe", rxf_s, '0);
    check("rst2_count", N'(cnt_s), N'(0));
    sb_s.delete();
    repeat (3) @(negedge a_clk);
    a_reset = 1'b0;
    repeat (DivS - 1) @(posedge a_clk);
    #1;
    check("rst2_clk_low", N'(clk_s), N'(0));
    @(posedge a_clk);
    #1;
    check("rst2_clk_rise", N'(clk_s), N'(1));
    repeat (4 * DivS) @(negedge a_clk);
    check("rst2_no_valid", N'(nval_s - v0), N'(0));
    check("rst2_idle", N'(busy_s), N'(0));

    // Back-to-back frames on the CLK_DIV=1 link with frame_count wrap
    t = rand_frame();
    tx_f = t;
    sb_f.push_back(exp_echo(t));
    sb_f.push_back(exp_echo(t));
    @(negedge a_clk);
    force u_fast.frame_count_q = 16'hFFFE;
    @(negedge a_clk);
    release u_fast.frame_count_q;
    start_f = 1'b1;
    wait_valid(1'b1, 700, cyc, fhi, ftx, thi, tout);
    check("b1_timeout", N'(tout), N'(0));
    pop_check("b1_rxframe", 1'b1, rxf_f);
    check("b1_count", N'(cnt_f), N'(16'hFFFF));
    @(negedge a_clk);
    check("b1_rearm", N'(busy_f), N'(1));
    start_f = 1'b0;
    wait_valid(1'b1, 700, cyc, fhi, ftx, thi, tout);
    check("b2_timeout", N'(tout), N'(0));
    pop_check("b2_rxframe", 1'b1, rxf_f);
    check("b2_count_wrap", N'(cnt_f), N'(16'h0000));
    check("b2_fsx_gap", N'(rise_f_last - rise_f_prev), N'(GapF));
    repeat (700) @(negedge a_clk);
    check("b2_nvalid", N'(nval_f), N'(2));
    check("b2_busy_end", N'(busy_f), N'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
